alu16: RTL and testbench

ALU16 -- requirements
Module: alu16

---
 rtl/alu16.sv | 130 +++++++++++++
 tb/tb_alu16.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu16.sv
// Registered 16-bit ALU: one-cycle latency, eight operations, and a full set of
// status flags captured together with the result.
module alu16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Z,
    output logic             Sign,
    output logic             Zero,
    output logic             Parity,
    output logic             Carry,
    output logic             Overflow,
    output logic             out_valid
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_ovf;

    logic [WIDTH-1:0] z_q, z_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    assign sum_ext  = {1'b0, X} + {1'b0, Y};
    // The extra MSB of the widened subtraction is the unsigned borrow.
    assign diff_ext = {1'b0, X} - {1'b0, Y};

    always_comb begin
        res       = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                res       = sum_ext[WIDTH-1:0];
                res_carry = sum_ext[WIDTH];
                res_ovf   = (X[WIDTH-1] == Y[WIDTH-1]) && (res[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SUB: begin
                res       = diff_ext[WIDTH-1:0];
                res_carry = diff_ext[WIDTH];
                res_ovf   = (X[WIDTH-1] != Y[WIDTH-1]) && (res[WIDTH-1] != X[WIDTH-1]);
            end
            OP_AND: res = X & Y;
            OP_OR:  res = X | Y;
            OP_XOR: res = X ^ Y;
            OP_NOT: res = ~X;
            OP_SHL: begin
                res       = {X[WIDTH-2:0], 1'b0};
                res_carry = X[WIDTH-1];
                res_ovf   = X[WIDTH-1] != X[WIDTH-2];
            end
            OP_SHR: begin
                res       = {1'b0, X[WIDTH-1:1]};
                res_carry = X[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        z_d      = z_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            z_d      = res;
            sign_d   = res[WIDTH-1];
            zero_d   = (res == '0);
            parity_d = ~^res;
            carry_d  = res_carry;
            ovf_d    = res_ovf;
            valid_d  = 1'b1;
        end
    end

    // Reset values describe Z=0, so Zero and Parity come up set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q      <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b1;
            parity_q <= 1'b1;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            z_q      <= z_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    assign Z         = z_q;
    assign Sign      = sign_q;
    assign Zero      = zero_q;
    assign Parity    = parity_q;
    assign Carry     = carry_q;
    assign Overflow  = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_alu16.sv
// Bench for alu16: integer-arithmetic reference model checked every cycle,
// plus literal expectations on hand-worked vectors.
module tb_alu16;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, NOT_ = 3'd5, SHL = 3'd6, SHR = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] X, Y;
    logic [2:0]  op;
    logic        in_valid;
    logic [15:0] Z;
    logic        Sign, Zero, Parity, Carry, Overflow, out_valid;

    int n_tests = 0;
    int n_fail  = 0;
    bit live    = 1'b0;

    alu16 #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .X(X), .Y(Y), .op(op), .in_valid(in_valid),
        .Z(Z), .Sign(Sign), .Zero(Zero), .Parity(Parity), .Carry(Carry),
        .Overflow(Overflow), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] z;
        logic        c;
        logic        v;
    } res_t;

    function automatic int to_signed(input int u);
        return (u >= 32768) ? u - 65536 : u;
    endfunction

    // Reference written with plain integer arithmetic and signed range tests.
    function automatic res_t ref_alu(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        res_t r;
        int   ia = int'(a);
        int   ib = int'(b);
        int   t;
        r = '0;
        case (o)
            3'd0: begin
                t   = ia + ib;
                r.z = 16'(t % 65536);
                r.c = (t > 65535);
                t   = to_signed(ia) + to_signed(ib);
                r.v = (t > 32767) || (t < -32768);
            end
            3'd1: begin
                t   = ia - ib + 65536;
                r.z = 16'(t % 65536);
                r.c = (ia < ib);
                t   = to_signed(ia) - to_signed(ib);
                r.v = (t > 32767) || (t < -32768);
            end
            3'd2: r.z = a & b;
            3'd3: r.z = a | b;
            3'd4: r.z = a ^ b;
            3'd5: r.z = 16'(65535 - ia);
            3'd6: begin
                r.z = 16'((ia * 2) % 65536);
                r.c = (ia >= 32768);
                t   = to_signed(ia) * 2;
                r.v = (t > 32767) || (t < -32768);
            end
            default: begin
                r.z = 16'(ia / 2);
                r.c = (ia % 2) == 1;
            end
        endcase
        return r;
    endfunction

    res_t        cur;
    logic [15:0] m_z;
    logic        m_c, m_v, m_ov;

    assign cur = ref_alu(op, X, Y);

    always @(posedge clk) begin
        if (!rst_n) begin
            m_z  <= 16'd0;
            m_c  <= 1'b0;
            m_v  <= 1'b0;
            m_ov <= 1'b0;
        end else if (in_valid) begin
            m_z  <= cur.z;
            m_c  <= cur.c;
            m_v  <= cur.v;
            m_ov <= 1'b1;
        end else begin
            m_ov <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("model.Z", Z, m_z);
            chk("model.Sign", 16'(Sign), 16'(m_z >= 16'h8000));
            chk("model.Zero", 16'(Zero), 16'(m_z == 16'd0));
            chk("model.Parity", 16'(Parity), 16'(($countones(m_z) % 2) == 0));
            chk("model.Carry", 16'(Carry), 16'(m_c));
            chk("model.Overflow", 16'(Overflow), 16'(m_v));
            chk("model.out_valid", 16'(out_valid), 16'(m_ov));
        end
    end

    // Order: Z, Sign, Zero, Parity, Carry, Overflow, out_valid.
    task automatic exp_all(input string tag, input logic [15:0] z, input logic s, input logic zr,
                           input logic p, input logic c, input logic v, input logic ov);
        chk({tag, ".Z"}, Z, z);
        chk({tag, ".Sign"}, 16'(Sign), 16'(s));
        chk({tag, ".Zero"}, 16'(Zero), 16'(zr));
        chk({tag, ".Parity"}, 16'(Parity), 16'(p));
        chk({tag, ".Carry"}, 16'(Carry), 16'(c));
        chk({tag, ".Overflow"}, 16'(Overflow), 16'(v));
        chk({tag, ".out_valid"}, 16'(out_valid), 16'(ov));
    endtask

    task automatic apply(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b, input logic v);
        op       = o;
        X        = a;
        Y        = b;
        in_valid = v;
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            4:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        X        = '0;
        Y        = '0;
        op       = '0;
        @(negedge clk);
        live = 1'b1;
        exp_all("RESET", 16'h0000, 0, 1, 1, 0, 0, 0);
        rst_n = 1'b1;

        apply(ADD, 16'h8FFF, 16'h8000, 1'b1);
        exp_all("ADD_OVF", 16'h0FFF, 0, 0, 1, 1, 1, 1);
        apply(ADD, 16'hFFFE, 16'h0002, 1'b1);
        exp_all("ADD_WRAP", 16'h0000, 0, 1, 1, 1, 0, 1);
        apply(SUB, 16'h0001, 16'h0002, 1'b1);
        exp_all("SUB_BORROW", 16'hFFFF, 1, 0, 1, 1, 0, 1);
        apply(SUB, 16'h8000, 16'h0001, 1'b1);
        exp_all("SUB_OVF", 16'h7FFF, 0, 0, 0, 0, 1, 1);
        // 8002 has two set bits, so even parity reads 1.
        apply(SHL, 16'hC001, 16'h0000, 1'b1);
        exp_all("SHL", 16'h8002, 1, 0, 1, 1, 0, 1);
        apply(SHR, 16'h0003, 16'h0000, 1'b1);
        exp_all("SHR", 16'h0001, 0, 0, 0, 1, 0, 1);
        apply(AND_, 16'hFFFF, 16'hFFFF, 1'b0);
        exp_all("HOLD", 16'h0001, 0, 0, 0, 1, 0, 0);
        apply(XOR_, 16'hF0F0, 16'hFF00, 1'b1);
        exp_all("XOR", 16'h0FF0, 0, 0, 1, 0, 0, 1);
        apply(NOT_, 16'h0000, 16'h1234, 1'b1);
        exp_all("NOT", 16'hFFFF, 1, 0, 1, 0, 0, 1);
        apply(OR_, 16'h4000, 16'h0001, 1'b1);
        exp_all("OR", 16'h4001, 0, 0, 1, 0, 0, 1);
        apply(SHL, 16'h4000, 16'h0000, 1'b1);
        exp_all("SHL_OVF", 16'h8000, 1, 0, 0, 0, 1, 1);

        rst_n = 1'b0;
        apply(ADD, 16'h0001, 16'h0001, 1'b1);
        exp_all("RESET_OP", 16'h0000, 0, 1, 1, 0, 0, 0);
        rst_n = 1'b1;
        apply(ADD, 16'h0001, 16'h0001, 1'b0);
        exp_all("RESET_HOLD", 16'h0000, 0, 1, 1, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            apply(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  $urandom_range(0, 3) != 0);
        end
        rst_n = 1'b1;
        apply(ADD, 16'h0000, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
